// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debounce filter.
// Defaults describe a 1 ms qualification window at 50 MHz and a 24-bit
// period measurement (about 335 ms at 50 MHz before stall is flagged).
package debounce_pkg;

  localparam int DEF_NCH        = 4;
  localparam int DEF_STABLE_CYC = 50000;
  localparam int DEF_PER_W      = 24;

  // Width of a stability counter that must be able to hold STABLE_CYC.
  // Never narrower than one bit, so STABLE_CYC=1 still elaborates.
  function automatic int cnt_w(input int stable_cyc);
    return (stable_cyc < 1) ? 1 : $clog2(stable_cyc + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter that
// qualifies a level change, registered rise/fall strobes, and a saturating
// rise-to-rise period counter with stall detection.
//
// Output protocol: period_vld is a one-clock strobe with no back-pressure.
// period is valid in the cycle period_vld is high and then holds until the
// next update. The consumer must sample it in that cycle or read the held
// value later. rise and fall are one-clock strobes in the first cycle that
// filt shows its new level.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter int PER_W      = DEF_PER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw,
  input  logic             en,
  output logic             filt,
  output logic             rise,
  output logic             fall,
  output logic [PER_W-1:0] period,
  output logic             period_vld,
  output logic             stalled
);

  localparam int               CNT_W       = cnt_w(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYC - 1);
  localparam logic [PER_W-1:0] PER_MAX     = '1;
  localparam logic [PER_W-1:0] PER_PRE_MAX = PER_MAX - PER_W'(1);

  logic             sync0;
  logic             s;
  logic [CNT_W-1:0] stab_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             armed;

  // Qualified change events, decided combinationally so that filt, the
  // strobes and the period capture all update on the same clock edge.
  logic accept;
  logic rise_evt;
  logic fall_evt;

  assign accept   = en && (s != filt) && (stab_cnt == CNT_LAST);
  assign rise_evt = accept && s;
  assign fall_evt = accept && !s;

  // Two-flop synchroniser; it keeps running while the filter is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync0 <= raw;
      s     <= sync0;
    end
  end

  // Stability counter: a change is taken only after s has disagreed with
  // filt for STABLE_CYC consecutive enabled clocks. Any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      filt     <= 1'b0;
    end else if (!en) begin
      stab_cnt <= '0;
    end else if (s == filt) begin
      stab_cnt <= '0;
    end else if (accept) begin
      filt     <= s;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + CNT_W'(1);
    end
  end

  // Registered edge strobes, aligned with the new value on filt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= rise_evt;
      fall <= fall_evt;
    end
  end

  // Period measurement. The counter holds clocks since the last rise. A rise
  // publishes it only when a previous rise is still trusted (armed). Reaching
  // the saturation value flags a stall and drops the arming, so the next rise
  // restarts the measurement without reporting a bogus period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      armed      <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (!en) begin
        per_cnt <= '0;
        armed   <= 1'b0;
      end else if (rise_evt) begin
        per_cnt <= PER_W'(1);
        if (armed && (per_cnt != PER_MAX)) begin
          period     <= per_cnt;
          period_vld <= 1'b1;
        end
        armed   <= 1'b1;
        stalled <= 1'b0;
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_W'(1);
        if (per_cnt == PER_PRE_MAX) begin
          stalled <= 1'b1;
          armed   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// NCH independent debounce channels for cadence, brake and switch inputs.
// This level only replicates the channel, fans out the shared enable and
// packs the per-channel period words onto one bus (channel i at
// [i*PER_W +: PER_W]).
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter int PER_W      = DEF_PER_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       raw,
  input  logic                 en,
  output logic [NCH-1:0]       filt,
  output logic [NCH-1:0]       rise,
  output logic [NCH-1:0]       fall,
  output logic [NCH*PER_W-1:0] period,
  output logic [NCH-1:0]       period_vld,
  output logic [NCH-1:0]       stalled
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYC (STABLE_CYC),
      .PER_W      (PER_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (raw[i]),
      .en         (en),
      .filt       (filt[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .period     (period[i*PER_W +: PER_W]),
      .period_vld (period_vld[i]),
      .stalled    (stalled[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: a timestamp-based reference model predicts
// strobe cycles, periods and levels. A monitor matches DUT strobes against
// queued expectations, and directed scenarios add end-to-end checks.
module tb_debounce_multi;

  localparam int NCH        = 4;
  localparam int STABLE_CYC = 16;
  localparam int PER_W      = 8;
  localparam int PER_MAX    = (1 << PER_W) - 1;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       raw   = '0;
  logic                 en    = 1'b0;
  logic [NCH-1:0]       filt;
  logic [NCH-1:0]       rise;
  logic [NCH-1:0]       fall;
  logic [NCH*PER_W-1:0] period;
  logic [NCH-1:0]       period_vld;
  logic [NCH-1:0]       stalled;

  debounce_multi #(
    .NCH        (NCH),
    .STABLE_CYC (STABLE_CYC),
    .PER_W      (PER_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (raw),
    .en         (en),
    .filt       (filt),
    .rise       (rise),
    .fall       (fall),
    .period     (period),
    .period_vld (period_vld),
    .stalled    (stalled)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel sees raw two samples late. A change is taken after
  // STABLE_CYC consecutive enabled samples that disagree with the filtered
  // level. Period = clocks since the reference time m_org (last rise, or the
  // first enabled clock after reset/disable), clamped at PER_MAX.
  bit   m_h1[NCH];
  bit   m_h2[NCH];
  bit   m_filt[NCH];
  bit   m_armed[NCH];
  bit   m_stalled[NCH];
  int   m_run[NCH];
  int   m_org[NCH];
  int   m_period[NCH];
  bit   mv;
  bit   m_rose;
  int   mage;

  logic [31:0] rise_q[NCH][$];
  logic [31:0] fall_q[NCH][$];
  logic [31:0] per_q[NCH][$];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n) begin
        m_h1[i] = 0; m_h2[i] = 0; m_filt[i] = 0; m_armed[i] = 0;
        m_stalled[i] = 0; m_run[i] = 0; m_period[i] = 0; m_org[i] = cyc + 1;
      end else begin
        mv = m_h2[i];
        m_h2[i] = m_h1[i];
        m_h1[i] = raw[i];
        if (!en) begin
          m_run[i] = 0;
          m_armed[i] = 0;
          m_org[i] = cyc + 1;
        end else begin
          m_rose = 0;
          if (mv == m_filt[i]) begin
            m_run[i] = 0;
          end else begin
            m_run[i]++;
            if (m_run[i] == STABLE_CYC) begin
              m_filt[i] = mv;
              m_run[i] = 0;
              if (mv) begin
                rise_q[i].push_back(32'(cyc));
                m_rose = 1;
              end else begin
                fall_q[i].push_back(32'(cyc));
              end
            end
          end
          mage = cyc - m_org[i];
          if (mage > PER_MAX) mage = PER_MAX;
          if (m_rose) begin
            if (m_armed[i] && mage < PER_MAX) begin
              m_period[i] = mage;
              per_q[i].push_back(32'(mage));
            end
            m_armed[i] = 1;
            m_stalled[i] = 0;
            m_org[i] = cyc;
          end else if (cyc - m_org[i] + 1 >= PER_MAX) begin
            m_stalled[i] = 1;
            m_armed[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int strobe_cnt[NCH];
  int vld_cnt[NCH];
  int last_per[NCH];
  int last_rise[NCH];

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rise[i]) begin
        strobe_cnt[i]++;
        last_rise[i] = cyc;
        if (rise_q[i].size() == 0) check($sformatf("rise%0d_unexpected", i), 1, 0);
        else check($sformatf("rise%0d_cycle", i), cyc, int'(rise_q[i].pop_front()));
      end
      if (fall[i]) begin
        strobe_cnt[i]++;
        if (fall_q[i].size() == 0) check($sformatf("fall%0d_unexpected", i), 1, 0);
        else check($sformatf("fall%0d_cycle", i), cyc, int'(fall_q[i].pop_front()));
      end
      if (period_vld[i]) begin
        vld_cnt[i]++;
        last_per[i] = int'(period[i*PER_W +: PER_W]);
        if (per_q[i].size() == 0) check($sformatf("vld%0d_unexpected", i), 1, 0);
        else check($sformatf("period%0d_value", i), last_per[i], int'(per_q[i].pop_front()));
      end
      if (rise_q[i].size() != 0) begin
        check($sformatf("rise%0d_missed", i), 0, 1);
        rise_q[i].delete();
      end
      if (fall_q[i].size() != 0) begin
        check($sformatf("fall%0d_missed", i), 0, 1);
        fall_q[i].delete();
      end
      if (per_q[i].size() != 0) begin
        check($sformatf("vld%0d_missed", i), 0, 1);
        per_q[i].delete();
      end
      check($sformatf("rise_fall_excl%0d", i), int'(rise[i] & fall[i]), 0);
      check($sformatf("filt%0d_level", i), int'(filt[i]), int'(m_filt[i]));
      check($sformatf("stalled%0d_level", i), int'(stalled[i]), int'(m_stalled[i]));
      check($sformatf("period%0d_level", i), int'(period[i*PER_W +: PER_W]), m_period[i]);
    end
  end

  function automatic int total_events();
    int t = 0;
    for (int i = 0; i < NCH; i++) t += strobe_cnt[i] + vld_cnt[i];
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  int   k;
  int   base;
  int   len;
  logic tgt;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      last_rise[i] = -1;
      strobe_cnt[i] = 0;
      vld_cnt[i] = 0;
      last_per[i] = 0;
    end
    step(3);
    check("reset_filt", int'(filt), 0);
    check("reset_rise_fall", int'({rise, fall}), 0);
    check("reset_period", int'(period), 0);
    check("reset_vld_stalled", int'({period_vld, stalled}), 0);
    rst_n = 1'b1;
    step(2);

    // 1: single clean step on ch0
    raw = 4'b0001;
    en  = 1'b1;
    k   = cyc + 1;
    step(25);
    check("t1_rise_cycle", last_rise[0], k + 17);
    check("t1_filt", int'(filt), 1);

    // 2: short random bursts between steady phases on ch0
    base = strobe_cnt[0];
    tgt  = 1'b0;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 15);
      repeat (len) begin
        raw[0] = 1'($urandom_range(0, 1));
        step(1);
      end
      raw[0] = tgt;
      step(40);
      tgt = ~tgt;
    end
    check("t2_strobes", strobe_cnt[0] - base, 20);
    check("t2_filt0", int'(filt[0]), 1);

    // 3: square wave on ch1, rises 100 clocks apart
    base = vld_cnt[1];
    repeat (5) begin
      raw[1] = 1'b1; step(50);
      raw[1] = 1'b0; step(50);
    end
    check("t3_vld_count", vld_cnt[1] - base, 4);
    check("t3_period", last_per[1], 100);

    // 4: stall on ch2, recovery, then a true period
    raw[2] = 1'b1; step(30);
    raw[2] = 1'b0; step(300);
    check("t4_stalled_set", int'(stalled[2]), 1);
    base = vld_cnt[2];
    raw[2] = 1'b1; step(30);
    check("t4_stalled_clr", int'(stalled[2]), 0);
    check("t4_no_vld_after_stall", vld_cnt[2] - base, 0);
    raw[2] = 1'b0; step(50);
    raw[2] = 1'b1; step(30);
    check("t4_vld_count", vld_cnt[2] - base, 1);
    check("t4_period", last_per[2], 80);

    // 5: enable low while raw[3] moves
    base = total_events();
    en = 1'b0;
    raw[3] = 1'b1; step(20);
    raw[3] = 1'b0; step(10);
    raw[3] = 1'b1; step(20);
    check("t5_no_strobes", total_events() - base, 0);
    check("t5_filt3_frozen", int'(filt[3]), 0);
    en = 1'b1;
    k  = cyc + 1;
    step(25);
    check("t5_rise_cycle", last_rise[3], k + 15);

    // random phase: all channels, occasional enable drops
    repeat (50) begin
      en  = ($urandom_range(0, 7) != 0);
      raw = 4'($urandom);
      step($urandom_range(1, 40));
    end
    en = 1'b1;
    step(40);

    // 6: reset in the middle of a count
    raw = 4'hF;
    step(40);
    check("t6_filt_all", int'(filt), 15);
    raw = 4'h0;
    step(6);
    rst_n = 1'b0;
    #1;
    check("t6_filt_zero", int'(filt), 0);
    check("t6_strobes_zero", int'({rise, fall, period_vld}), 0);
    check("t6_period_zero", int'(period), 0);
    check("t6_stalled_zero", int'(stalled), 0);
    step(3);
    rst_n = 1'b1;
    base = total_events();
    step(20);
    check("t6_no_strobe_after_release", total_events() - base, 0);
    check("t6_filt_after_release", int'(filt), 0);

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    check("watchdog_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
